// File: rtl/vector_abs_pipe.sv
// Three-stage pipelined vector magnitude approximation: |v| ~ max + min/2.
// Define VECTOR_ABS_FINE_EN to use the refined rule max(mx, mx - mx/8 + mn/2) in the last stage.
module vector_abs_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          SIGNED_IN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH:0]   abs_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   // The most negative two's-complement value maps onto 2^(WIDTH-1), which fits unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (SIGNED_IN && v[WIDTH-1]) begin
         r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic             en_s;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_ax_q, s1_ax_d;
   logic [WIDTH-1:0] s1_ay_q, s1_ay_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_mx_q, s2_mx_d;
   logic [WIDTH-1:0] s2_mn_q, s2_mn_d;
   logic             s3_valid_q, s3_valid_d;
   logic [WIDTH:0]   s3_abs_q, s3_abs_d;
   logic [WIDTH-1:0] mx_s, mn_s;
   logic [WIDTH:0]   mx_ext_s, mn_half_s, result_s;
`ifdef VECTOR_ABS_FINE_EN
   logic [WIDTH:0]   fine_s;
`endif

   assign en_s        = out_ready_i | ~s3_valid_q;
   assign in_ready_o  = en_s;
   assign abs_o       = s3_abs_q;
   assign out_valid_o = s3_valid_q;

   // Sort the two magnitudes; equal values take the first branch so mx = mn.
   always_comb begin
      if (s1_ax_q >= s1_ay_q) begin
         mx_s = s1_ax_q;
         mn_s = s1_ay_q;
      end else begin
         mx_s = s1_ay_q;
         mn_s = s1_ax_q;
      end
   end

   // Final combine evaluated at WIDTH+1 bits so nothing is truncated.
   always_comb begin
      mx_ext_s  = {1'b0, s2_mx_q};
      mn_half_s = {1'b0, s2_mn_q} >> 1;
`ifdef VECTOR_ABS_FINE_EN
      fine_s = mx_ext_s - (mx_ext_s >> 3) + mn_half_s;
      if (fine_s > mx_ext_s) begin
         result_s = fine_s;
      end else begin
         result_s = mx_ext_s;
      end
`else
      result_s = mx_ext_s + mn_half_s;
`endif
   end

   // Whole pipe advances in lockstep when en is high, otherwise every stage holds.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_ax_d    = s1_ax_q;
      s1_ay_d    = s1_ay_q;
      s2_valid_d = s2_valid_q;
      s2_mx_d    = s2_mx_q;
      s2_mn_d    = s2_mn_q;
      s3_valid_d = s3_valid_q;
      s3_abs_d   = s3_abs_q;
      if (en_s) begin
         s1_valid_d = in_valid_i;
         s1_ax_d    = mag(x_i);
         s1_ay_d    = mag(y_i);
         s2_valid_d = s1_valid_q;
         s2_mx_d    = mx_s;
         s2_mn_d    = mn_s;
         s3_valid_d = s2_valid_q;
         s3_abs_d   = result_s;
      end else begin
         s1_valid_d = s1_valid_q;
         s2_valid_d = s2_valid_q;
         s3_valid_d = s3_valid_q;
      end
   end

   // Pipeline registers with synchronous active-low reset clearing data and valid bits.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_ax_q    <= {WIDTH{1'b0}};
         s1_ay_q    <= {WIDTH{1'b0}};
         s2_valid_q <= 1'b0;
         s2_mx_q    <= {WIDTH{1'b0}};
         s2_mn_q    <= {WIDTH{1'b0}};
         s3_valid_q <= 1'b0;
         s3_abs_q   <= {(WIDTH+1){1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_ax_q    <= s1_ax_d;
         s1_ay_q    <= s1_ay_d;
         s2_valid_q <= s2_valid_d;
         s2_mx_q    <= s2_mx_d;
         s2_mn_q    <= s2_mn_d;
         s3_valid_q <= s3_valid_d;
         s3_abs_q   <= s3_abs_d;
      end
   end

endmodule

// File: tb/tb_vector_abs_pipe.sv
// Scoreboard bench for vector_abs_pipe: a signed and an unsigned instance share one stimulus stream.
module tb_vector_abs_pipe;

   typedef struct packed {
      logic [32:0] val;
      logic [31:0] cyc;
      logic        lat;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] x_in, y_in;
   logic        in_valid, out_ready;
   logic        in_ready_s, in_ready_u, out_valid_s, out_valid_u;
   logic [32:0] abs_s, abs_u;
   logic [31:0] cyc;

   ent_t        q_s[$];
   ent_t        q_u[$];
   int          n_vec = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        hold_prev [2];
   logic [32:0] prev_abs  [2];

   localparam logic [31:0] TX [9] = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h8,
                                      32'h8, 32'h0, 32'h7FFFFFFF, 32'h5};
   localparam logic [31:0] TY [9] = '{32'h4, 32'hFFFFFFFF, 32'h4, 32'h0, 32'h8,
                                      32'h0, 32'h0, 32'h80000000, 32'hFFFFFFF0};
`ifdef VECTOR_ABS_FINE_EN
   localparam logic [32:0] TEU [9] = '{33'h5, 33'h15FFFFFFF, 33'hFFFFFFFD, 33'h80000000, 33'hB,
                                       33'h8, 33'h0, 33'hAFFFFFFF, 33'hFFFFFFF0};
   localparam logic [32:0] TES [9] = '{33'h5, 33'h1, 33'h5, 33'h80000000, 33'hB,
                                       33'h8, 33'h0, 33'hAFFFFFFF, 33'h10};
`else
   localparam logic [32:0] TEU [9] = '{33'h5, 33'h17FFFFFFE, 33'hFFFFFFFF, 33'h80000000, 33'hC,
                                       33'h8, 33'h0, 33'hBFFFFFFF, 33'hFFFFFFF2};
   localparam logic [32:0] TES [9] = '{33'h5, 33'h1, 33'h5, 33'h80000000, 33'hC,
                                       33'h8, 33'h0, 33'hBFFFFFFF, 33'h12};
`endif

   vector_abs_pipe #(.WIDTH(32), .SIGNED_IN(1'b1)) u_dut_s (
      .clk_i(clk), .rst_ni(rst_n), .x_i(x_in), .y_i(y_in), .in_valid_i(in_valid),
      .in_ready_o(in_ready_s), .abs_o(abs_s), .out_valid_o(out_valid_s), .out_ready_i(out_ready)
   );

   vector_abs_pipe #(.WIDTH(32), .SIGNED_IN(1'b0)) u_dut_u (
      .clk_i(clk), .rst_ni(rst_n), .x_i(x_in), .y_i(y_in), .in_valid_i(in_valid),
      .in_ready_o(in_ready_u), .abs_o(abs_u), .out_valid_o(out_valid_u), .out_ready_i(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 32'd1;

   // Reference magnitude computed with wide integers.
   function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
      longint ax, ay, mx, mn, r;
      ax = sgn ? longint'($signed(x)) : longint'({1'b0, x});
      ay = sgn ? longint'($signed(y)) : longint'({1'b0, y});
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      mx = (ax > ay) ? ax : ay;
      mn = (ax > ay) ? ay : ax;
`ifdef VECTOR_ABS_FINE_EN
      r = mx - mx / 8 + mn / 2;
      if (r < mx) r = mx;
`else
      r = mx + mn / 2;
`endif
      return r[32:0];
   endfunction

   task automatic cmp(input string nm, input logic [32:0] act, input logic [32:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Called just after a negedge: drive inputs, then push expectations for accepted samples.
   task automatic drive(input bit vld, input logic [31:0] x, input logic [31:0] y, input bit ordy,
                        input bit lat, input logic [32:0] eu, input logic [32:0] es, output bit acc);
      ent_t e;
      in_valid  = vld;
      x_in      = x;
      y_in      = y;
      out_ready = ordy;
      #1;
      acc = 1'b0;
      if (rst_n && vld && in_ready_s) begin
         e = '{val: es, cyc: cyc, lat: lat};
         q_s.push_back(e);
         acc = 1'b1;
      end
      if (rst_n && vld && in_ready_u) begin
         e = '{val: eu, cyc: cyc, lat: lat};
         q_u.push_back(e);
      end
      if (acc) n_vec++;
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while ((q_s.size() != 0 || q_u.size() != 0) && n < 60) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 33'h0, 33'h0, acc);
         n++;
      end
      if (q_s.size() != 0 || q_u.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d/%0d results still outstanding, expected 0", q_s.size(), q_u.size());
      end
      repeat (4) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 33'h0, 33'h0, acc);
      end
   endtask

   task automatic check_port(input int id, input logic v, input logic [32:0] a);
      ent_t e;
      if (rst_n && hold_prev[id]) begin
         cmp($sformatf("stall_valid[%0d]", id), {32'h0, v}, 33'h1);
         cmp($sformatf("stall_stable[%0d]", id), a, prev_abs[id]);
      end
      if (rst_n && v && out_ready) begin
         if ((id == 0 && q_s.size() == 0) || (id == 1 && q_u.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_out[%0d]: got 0x%0h, expected no output", id, a);
         end else begin
            e = (id == 0) ? q_s.pop_front() : q_u.pop_front();
            cmp($sformatf("abs[%0d]", id), a, e.val);
            if (e.lat) cmp($sformatf("latency[%0d]", id), {1'b0, cyc - e.cyc}, 33'd3);
         end
      end
      hold_prev[id] = rst_n && v && !out_ready;
      prev_abs[id]  = a;
   endtask

   // Output monitor, sampling mid-cycle after the driver has settled.
   initial begin
      hold_prev[0] = 1'b0;
      hold_prev[1] = 1'b0;
      prev_abs[0]  = 33'h0;
      prev_abs[1]  = 33'h0;
      forever begin
         @(negedge clk);
         #2;
         check_port(0, out_valid_s, abs_s);
         check_port(1, out_valid_u, abs_u);
      end
   end

   initial begin
      bit acc;
      int k, stall, sent, budget;
      bit started;
      logic [31:0] rx, ry;
      cyc       = 32'd0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x_in      = 32'h0;
      y_in      = 32'h0;

      // Reset state.
      repeat (3) @(negedge clk);
      cmp("rst_in_ready", {32'h0, in_ready_s}, 33'h1);
      cmp("rst_out_valid_s", {32'h0, out_valid_s}, 33'h0);
      cmp("rst_out_valid_u", {32'h0, out_valid_u}, 33'h0);
      cmp("rst_abs_s", abs_s, 33'h0);
      rst_n = 1'b1;

      // Directed table, back-to-back with downstream always ready.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(1'b1, TX[i], TY[i], 1'b1, 1'b1, TEU[i], TES[i], acc);
         if (!acc) cmp("table_accept", 33'h0, 33'h1);
      end
      drain();

      // Backpressure: stall 5 cycles once the first result shows.
      k = 0; stall = 0; started = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (!started && out_valid_s) begin
            started = 1'b1;
            stall   = 5;
         end
         drive(k < 4, k + 1, 32'h0, stall == 0, 1'b0, k + 1, k + 1, acc);
         if (stall > 0) cmp("stall_in_ready", {32'h0, in_ready_s}, 33'h0);
         if (acc) k++;
         if (stall > 0) stall--;
      end
      cmp("bp_started", {32'h0, started}, 33'h1);
      drain();

      // Reset mid-operation: two samples in flight are discarded.
      @(negedge clk);
      drive(1'b1, 32'd10, 32'd0, 1'b1, 1'b0, 33'd10, 33'd10, acc);
      @(negedge clk);
      drive(1'b1, 32'd20, 32'd0, 1'b1, 1'b0, 33'd20, 33'd20, acc);
      @(negedge clk);
      rst_n = 1'b0;
      q_s.delete();
      q_u.delete();
      drive(1'b1, 32'd7, 32'd7, 1'b1, 1'b0, 33'd10, 33'd10, acc);
      cmp("mid_rst_in_ready", {32'h0, in_ready_s}, 33'h1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'd3, 32'd4, 1'b1, 1'b1, 33'd5, 33'd5, acc);
      cmp("post_rst_valid", {32'h0, out_valid_s}, 33'h0);
      cmp("post_rst_abs", abs_s, 33'h0);
      drain();

      // Random stress with random valid and ready.
      sent = 0; budget = 0;
      while (sent < 1000 && budget < 20000) begin
         @(negedge clk);
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
         drive($urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 3) != 0, 1'b0,
               model(rx, ry, 1'b0), model(rx, ry, 1'b1), acc);
         if (acc) sent++;
         budget++;
      end
      if (sent < 1000) cmp("stress_budget", sent, 33'd1000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
